// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes and every datapath select/op code driven by the controller.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL
  } mc_state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: latched instruction fields and flags in,
// selects and write enables out.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct_3;
  logic [6:0] funct_7;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funct_3, funct_7, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_ctrl, imm_src, reg_write, instr_done, illegal
  );

  modport slave (
    output opcode, funct_3, funct_7, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_ctrl, imm_src, reg_write, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_controller_alu_dec.sv
// ALU decoder: maps the FSM's alu_op plus funct fields onto an ALU operation.
module mc_alu_dec
  import mc_pkg::*;
(
  input  alu_op_t    alu_op_i,
  input  logic [2:0] funct_3_i,
  input  logic       op5_i,
  input  logic       funct7_5_i,
  output logic [2:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_3_i)
          // sub only for R-type; I-type addi reuses funct_7 bits as immediate
          3'b000:  alu_ctrl_o = (op5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b110:  alu_ctrl_o = ALU_OR;
          3'b111:  alu_ctrl_o = ALU_AND;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute per instruction
// class and drives every datapath select and enable, stalling on mem_ready.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  mc_state_t  state_q, state_d;
  alu_op_t    alu_op;
  logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c, done_c, illegal_c;
  logic       adr_src_c;
  logic [1:0] result_src_c, src_a_c, src_b_c;
  logic       unused_funct_7;

  assign unused_funct_7 = ^{bus.funct_7[6], bus.funct_7[4:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    alu_op       = ALUOP_ADD;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    done_c       = 1'b0;
    illegal_c    = 1'b0;
    adr_src_c    = 1'b0;
    result_src_c = RES_ALUOUT;
    src_a_c      = SRCA_PC;
    src_b_c      = SRCB_RS2;
    case (state_q)
      S_FETCH: begin
        src_b_c      = SRCB_FOUR;
        result_src_c = RES_ALU;
        pc_write_c   = bus.mem_ready;
        ir_write_c   = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        src_a_c = SRCA_OLDPC;
        src_b_c = SRCB_IMM;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
            done_c    = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        src_a_c = SRCA_RS1;
        src_b_c = SRCB_IMM;
        state_d = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_src_c = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src_c = RES_MEMDATA;
        reg_write_c  = 1'b1;
        done_c       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        if (bus.mem_ready) begin
          done_c  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        src_a_c = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        src_a_c = SRCA_RS1;
        src_b_c = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        src_a_c    = SRCA_RS1;
        alu_op     = ALUOP_SUB;
        pc_write_c = bus.zero ^ bus.funct_3[0];
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // ALU forms the link value while the PC takes the target from DECODE
        src_a_c    = SRCA_OLDPC;
        src_b_c    = SRCB_FOUR;
        pc_write_c = 1'b1;
        state_d    = S_ALU_WB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .alu_op_i   (alu_op),
    .funct_3_i  (bus.funct_3),
    .op5_i      (bus.opcode[5]),
    .funct7_5_i (bus.funct_7[5]),
    .alu_ctrl_o (bus.alu_ctrl)
  );

  always_comb begin
    case (bus.opcode)
      OP_LW, OP_I: bus.imm_src = IMM_I;
      OP_SW:       bus.imm_src = IMM_S;
      OP_BR:       bus.imm_src = IMM_B;
      OP_JAL:      bus.imm_src = IMM_J;
      default:     bus.imm_src = IMM_I;
    endcase
  end

  // Enables are gated by reset directly so an abort needs no clock edge.
  assign bus.pc_write   = rst & pc_write_c;
  assign bus.ir_write   = rst & ir_write_c;
  assign bus.mem_write  = rst & mem_write_c;
  assign bus.reg_write  = rst & reg_write_c;
  assign bus.instr_done = rst & done_c;
  assign bus.illegal    = rst & illegal_c;
  assign bus.adr_src    = adr_src_c;
  assign bus.result_src = result_src_c;
  assign bus.alu_src_a  = src_a_c;
  assign bus.alu_src_b  = src_b_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: compares the full control word
// every cycle against hand-computed values.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst;
  int unsigned vectors = 0;
  int unsigned errs = 0;
  logic [17:0] obs_w;

  multicycle_controller_if bus_if ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  assign obs_w = {bus_if.pc_write, bus_if.adr_src, bus_if.mem_write, bus_if.ir_write,
                  bus_if.result_src, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_ctrl,
                  bus_if.imm_src, bus_if.reg_write, bus_if.instr_done, bus_if.illegal};

  function automatic logic [17:0] cw(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] ctl, input logic [1:0] imm,
                                     input logic rw, input logic dn, input logic il);
    return {pcw, adr, mw, irw, rs, a, b, ctl, imm, rw, dn, il};
  endfunction

  task automatic chk(input string tag, input logic [17:0] exp);
    #1;
    vectors++;
    assert (obs_w === exp) else begin
      errs++;
      $error("FAIL %s: observed %b required %b", tag, obs_w, exp);
    end
  endtask

  task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [1:0] imm);
    @(negedge clk);
    bus_if.opcode    = op;
    bus_if.funct_3   = f3;
    bus_if.funct_7   = f7;
    bus_if.mem_ready = 1'b1;
    chk("fetch", cw(1,0,0,1,2'b10,2'b00,2'b10,3'b000,imm,0,0,0));
    @(negedge clk);
    chk("decode", cw(0,0,0,0,2'b00,2'b01,2'b01,3'b000,imm,0,0,0));
  endtask

  task automatic step(input string tag, input logic [17:0] exp);
    @(negedge clk);
    chk(tag, exp);
  endtask

  initial begin
    rst              = 1'b0;
    bus_if.opcode    = 7'b0000011;
    bus_if.funct_3   = 3'b010;
    bus_if.funct_7   = '0;
    bus_if.zero      = 1'b0;
    bus_if.mem_ready = 1'b1;

    @(negedge clk);
    chk("reset", cw(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0,0));
    rst              = 1'b1;
    bus_if.mem_ready = 1'b0;

    // lw, no stall
    fetch_decode(7'b0000011, 3'b010, 7'b0000000, 2'b00);
    step("lw_adr",  cw(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0,0));
    step("lw_read", cw(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0));
    step("lw_wb",   cw(0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b00,1,1,0));

    // fetch stall then R-type sub
    bus_if.opcode  = 7'b0110011;
    bus_if.funct_3 = 3'b000;
    bus_if.funct_7 = 7'b0100000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_if.mem_ready = 1'b0;
      chk("fetch_stall", cw(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0,0));
    end
    fetch_decode(7'b0110011, 3'b000, 7'b0100000, 2'b00);
    step("r_sub_exec", cw(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0,0,0));
    step("r_sub_wb",   cw(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,1,0));

    fetch_decode(7'b0110011, 3'b000, 7'b0000000, 2'b00);
    step("r_add_exec", cw(0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b00,0,0,0));
    step("r_add_wb",   cw(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,1,0));

    fetch_decode(7'b0010011, 3'b000, 7'b0100000, 2'b00);
    step("addi_f7_exec", cw(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0,0));
    step("addi_f7_wb",   cw(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,1,0));

    fetch_decode(7'b0010011, 3'b010, 7'b0000000, 2'b00);
    step("slti_exec", cw(0,0,0,0,2'b00,2'b10,2'b01,3'b101,2'b00,0,0,0));
    step("slti_wb",   cw(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,1,0));

    fetch_decode(7'b0010011, 3'b110, 7'b0000000, 2'b00);
    step("ori_exec", cw(0,0,0,0,2'b00,2'b10,2'b01,3'b011,2'b00,0,0,0));
    step("ori_wb",   cw(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,1,0));

    fetch_decode(7'b0110011, 3'b111, 7'b0000000, 2'b00);
    step("and_exec", cw(0,0,0,0,2'b00,2'b10,2'b00,3'b010,2'b00,0,0,0));
    step("and_wb",   cw(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,1,0));

    fetch_decode(7'b0010011, 3'b100, 7'b0100000, 2'b00);
    step("xori_exec", cw(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0,0));
    step("xori_wb",   cw(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,1,0));

    // branches
    bus_if.zero = 1'b1;
    fetch_decode(7'b1100011, 3'b000, 7'b0000000, 2'b10);
    step("beq_taken", cw(1,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,1,0));
    fetch_decode(7'b1100011, 3'b001, 7'b0000000, 2'b10);
    step("bne_not_taken", cw(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,1,0));
    bus_if.zero = 1'b0;
    fetch_decode(7'b1100011, 3'b000, 7'b0000000, 2'b10);
    step("beq_not_taken", cw(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,1,0));
    fetch_decode(7'b1100011, 3'b001, 7'b0000000, 2'b10);
    step("bne_taken", cw(1,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,1,0));

    // illegal opcode: DECODE pulses illegal and done, next cycle FETCH
    @(negedge clk);
    bus_if.opcode = 7'b0000000;
    chk("illegal_fetch", cw(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0,0));
    step("illegal_decode", cw(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,1,1));

    // lw with one MEM_READ stall cycle
    fetch_decode(7'b0000011, 3'b010, 7'b0000000, 2'b00);
    step("lws_adr", cw(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0,0));
    @(negedge clk);
    bus_if.mem_ready = 1'b0;
    chk("lws_read_wait", cw(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0));
    @(negedge clk);
    bus_if.mem_ready = 1'b1;
    chk("lws_read_done", cw(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0));
    step("lws_wb", cw(0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b00,1,1,0));

    // sw completing immediately
    fetch_decode(7'b0100011, 3'b010, 7'b0000000, 2'b01);
    step("sw_adr",  cw(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0,0));
    step("sw_write", cw(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,1,0));

    // sw stalled, reset asserted mid-MEM_WRITE
    fetch_decode(7'b0100011, 3'b010, 7'b0000000, 2'b01);
    step("swr_adr", cw(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0,0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus_if.mem_ready = 1'b0;
      chk("swr_write_wait", cw(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0,0));
    end
    @(negedge clk);
    chk("swr_write_wait", cw(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0,0));
    rst = 1'b0;
    chk("swr_reset_now", cw(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0,0));
    @(negedge clk);
    bus_if.opcode    = 7'b1101111;
    bus_if.mem_ready = 1'b1;
    chk("reset_held", cw(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b11,0,0,0));

    // release and run jal
    @(negedge clk);
    rst = 1'b1;
    chk("jal_fetch",  cw(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b11,0,0,0));
    step("jal_decode", cw(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b11,0,0,0));
    step("jal_jal",    cw(1,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0,0,0));
    step("jal_wb",     cw(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b11,1,1,0));
    step("jal_next_fetch", cw(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b11,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
